// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: sweeps a register range through one register-file read
// port and streams {address, data} beats over valid/ready while holding Busy.
module regfile_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              Start_i,
    input  logic [ADDR_W-1:0] FirstReg_i,
    input  logic [ADDR_W-1:0] LastReg_i,
    input  logic              Abort_i,
    output logic [ADDR_W-1:0] RfReadAddr_o,
    input  logic [DATA_W-1:0] RfReadData_i,
    output logic              OutValid_o,
    input  logic              OutReady_i,
    output logic [ADDR_W-1:0] OutAddr_o,
    output logic [DATA_W-1:0] OutData_o,
    output logic              Busy_o,
    output logic              Done_o,
    output logic              RangeErr_o
);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   cur_q, last_q, rd_addr_q, out_addr_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_valid_q, busy_q, done_q, range_err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            rd_addr_q   <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start_i) begin
                        if (FirstReg_i <= LastReg_i) begin
                            cur_q     <= FirstReg_i;
                            last_q    <= LastReg_i;
                            rd_addr_q <= FirstReg_i;
                            busy_q    <= 1'b1;
                            state_q   <= READ;
                        end else begin
                            range_err_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (Abort_i) begin
                        rd_addr_q <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        out_data_q  <= RfReadData_i;
                        out_addr_q  <= cur_q;
                        out_valid_q <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    // Abort beats a same-cycle handshake: the beat is dropped.
                    if (Abort_i) begin
                        out_valid_q <= 1'b0;
                        rd_addr_q   <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (OutReady_i) begin
                        out_valid_q <= 1'b0;
                        if (cur_q == last_q) begin
                            rd_addr_q <= '0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            cur_q     <= cur_q + ADDR_W'(1);
                            rd_addr_q <= cur_q + ADDR_W'(1);
                            state_q   <= READ;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign RfReadAddr_o = rd_addr_q;
    assign OutValid_o   = out_valid_q;
    assign OutAddr_o    = out_addr_q;
    assign OutData_o    = out_data_q;
    assign Busy_o       = busy_q;
    assign Done_o       = done_q;
    assign RangeErr_o   = range_err_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: vector table, hand-written corner sequences,
// and randomized dumps scored against a queue of expected {addr,data} beats.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Start, Abort, OutReady;
    logic [4:0]  FirstReg, LastReg, RfReadAddr, OutAddr;
    logic [31:0] RfReadData, OutData;
    logic        OutValid, Busy, Done, RangeErr;
    logic [31:0] rf [0:31];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    assign RfReadData = rf[RfReadAddr];

    regfile_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .Start_i(Start), .FirstReg_i(FirstReg),
        .LastReg_i(LastReg), .Abort_i(Abort), .RfReadAddr_o(RfReadAddr),
        .RfReadData_i(RfReadData), .OutValid_o(OutValid), .OutReady_i(OutReady),
        .OutAddr_o(OutAddr), .OutData_o(OutData), .Busy_o(Busy), .Done_o(Done),
        .RangeErr_o(RangeErr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 + i;
    endtask

    // mode 0: always ready; 1: random ready; 2: stall 3 cycles on beat addr 5
    task automatic run_dump(input int f, input int l, input int mode, input bit poke,
                            output int beats, output int rerr, output int dones,
                            output int fv, output int lhs, output int dc);
        logic [4:0]  qa[$];
        logic [31:0] qd[$];
        logic [4:0]  pa;
        logic [31:0] pd;
        bit pv, pr;
        int stall, tail, cyc;
        beats = 0; rerr = 0; dones = 0; fv = -1; lhs = -1; dc = -1;
        stall = 0; tail = -1; pv = 0; pr = 0; pa = '0; pd = '0;
        if (f <= l) for (int a = f; a <= l; a++) begin
            qa.push_back(5'(a));
            qd.push_back(rf[a]);
        end
        FirstReg = 5'(f); LastReg = 5'(l); Start = 1'b1; OutReady = 1'b0;
        cyc = 0;
        while (tail <= 3 && cyc < 1000) begin
            if (cyc > 0) begin
                Start = poke && cyc == 10;
                if (poke && cyc == 10) begin FirstReg = 5'd0; LastReg = 5'd0; end
            end
            case (mode)
                0: OutReady = 1'b1;
                1: OutReady = 1'($urandom % 2);
                default: begin
                    if (OutValid && OutAddr == 5'd5 && stall < 3) begin
                        OutReady = 1'b0; stall++;
                    end else OutReady = 1'b1;
                end
            endcase
            if (pv && !pr) begin
                chk("stall_valid", OutValid, 1);
                chk("stall_addr", OutAddr, pa);
                chk("stall_data", OutData, pd);
            end
            if (OutValid && fv < 0) fv = cyc;
            if (OutValid) chk("busy_with_valid", Busy, 1);
            if (OutValid && OutReady) begin
                if (qa.size() == 0) chk("extra_beat", 1, 0);
                else begin
                    chk("beat_addr", OutAddr, qa[0]);
                    chk("beat_data", OutData, qd[0]);
                    void'(qa.pop_front());
                    void'(qd.pop_front());
                end
                beats++; lhs = cyc;
            end
            if (Busy && !OutValid && qa.size() > 0) chk("rf_read_addr", RfReadAddr, qa[0]);
            if (Done) begin
                dones++; dc = cyc;
                chk("busy_at_done", Busy, 0);
                chk("beats_left_at_done", qa.size(), 0);
            end
            if (RangeErr) rerr++;
            if (f > l) begin
                chk("rerr_no_busy", Busy, 0);
                chk("rerr_no_valid", OutValid, 0);
            end
            pv = OutValid; pr = OutReady; pa = OutAddr; pd = OutData;
            if ((Done || RangeErr) && tail < 0) tail = 0;
            if (tail >= 0) tail++;
            step();
            cyc++;
        end
        if (tail <= 3) chk("dump_timeout", cyc, 0);
        Start = 1'b0; OutReady = 1'b0;
    endtask

    typedef struct {
        int f, l, mode;
        bit poke;
        int beats, rerr, dones, fv, lhs;
    } vec_t;

    initial begin
        vec_t vt [7];
        int beats, rerr, dones, fv, lhs, dc, f, l, n;

        vt[0] = '{0, 31, 0, 1, 32, 0, 1, 2, 64};
        vt[1] = '{4, 6, 2, 0, 3, 0, 1, 2, 9};
        vt[2] = '{7, 7, 0, 0, 1, 0, 1, 2, 2};
        vt[3] = '{9, 3, 0, 0, 0, 1, 0, -1, -1};
        vt[4] = '{31, 31, 0, 0, 1, 0, 1, 2, 2};
        vt[5] = '{30, 31, 0, 0, 2, 0, 1, 2, 4};
        vt[6] = '{0, 0, 0, 0, 1, 0, 1, 2, 2};

        rst_n = 1'b0; Start = 1'b0; Abort = 1'b0; OutReady = 1'b0;
        FirstReg = '0; LastReg = '0;
        preload();
        #12;
        chk("rst_valid", OutValid, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_rerr", RangeErr, 0);
        chk("rst_rdaddr", RfReadAddr, 0);
        chk("rst_outaddr", OutAddr, 0);
        chk("rst_outdata", OutData, 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            run_dump(vt[i].f, vt[i].l, vt[i].mode, vt[i].poke, beats, rerr, dones, fv, lhs, dc);
            chk($sformatf("v%0d_beats", i), beats, vt[i].beats);
            chk($sformatf("v%0d_rerr", i), rerr, vt[i].rerr);
            chk($sformatf("v%0d_dones", i), dones, vt[i].dones);
            chk($sformatf("v%0d_first_valid", i), fv, vt[i].fv);
            chk($sformatf("v%0d_last_hs", i), lhs, vt[i].lhs);
            if (vt[i].dones == 1) chk($sformatf("v%0d_done_cyc", i), dc, vt[i].lhs + 1);
        end

        // Abort on addr 10 with a simultaneous handshake
        FirstReg = 5'd0; LastReg = 5'd31; Start = 1'b1; OutReady = 1'b1;
        step();
        Start = 1'b0;
        n = 0;
        while (!(OutValid && OutAddr == 5'd10) && n < 100) begin step(); n++; end
        chk("abort_reach_addr10", n < 100, 1);
        Abort = 1'b1;
        step();
        Abort = 1'b0; OutReady = 1'b0;
        chk("abort_valid", OutValid, 0);
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_done_later", Done, 0);
            chk("abort_no_valid_later", OutValid, 0);
        end
        run_dump(0, 1, 0, 0, beats, rerr, dones, fv, lhs, dc);
        chk("after_abort_beats", beats, 2);
        chk("after_abort_dones", dones, 1);

        // Async reset between edges while in SEND
        FirstReg = 5'd2; LastReg = 5'd5; Start = 1'b1; OutReady = 1'b0;
        step();
        Start = 1'b0;
        n = 0;
        while (!OutValid && n < 10) begin step(); n++; end
        chk("rst_mid_reach_send", OutValid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", OutValid, 0);
        chk("rst_mid_busy", Busy, 0);
        chk("rst_mid_done", Done, 0);
        chk("rst_mid_rdaddr", RfReadAddr, 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        run_dump(2, 3, 0, 0, beats, rerr, dones, fv, lhs, dc);
        chk("after_rst_beats", beats, 2);
        chk("after_rst_dones", dones, 1);
        chk("after_rst_first_valid", fv, 2);

        // Random ranges, random contents, random backpressure
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            f = int'($urandom % 32);
            l = int'($urandom % 32);
            run_dump(f, l, 1, 0, beats, rerr, dones, fv, lhs, dc);
            chk($sformatf("rnd%0d_beats", it), beats, (f <= l) ? l - f + 1 : 0);
            chk($sformatf("rnd%0d_rerr", it), rerr, (f > l) ? 1 : 0);
            chk($sformatf("rnd%0d_dones", it), dones, (f <= l) ? 1 : 0);
            if (f <= l) chk($sformatf("rnd%0d_done_cyc", it), dc, lhs + 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
